trig_counter_bank: RTL and testbench

//   Parametrised bank of NUM_CH independent up/down counters driven by host trigger pulses (TriggerIn bits).

---
 rtl/trig_counter_pkg.sv | 37 +++
 rtl/trig_counter_ch.sv | 77 +++++++
 rtl/trig_counter_bank.sv | 67 ++++++
 tb/tb_trig_counter_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/trig_counter_pkg.sv
// trig_counter_pkg: shared constants, channel op encoding and helpers for
// the trigger-driven counter bank.
//   MODE_WRAP / MODE_SAT : values of the per-channel sat_mode level
//   ch_op_e              : resolved per-channel operation, after priority
//   max_val()            : 2^w - 1 for a counter of width w (w up to 64)
//   decode_op()          : priority encoder clr > load > up&down hold > up > down
package trig_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_UP   = 3'd3,
    OP_DOWN = 3'd4
  } ch_op_e;

  function automatic logic [63:0] max_val(input int w);
    logic [64:0] t;
    t = (65'd1 << w) - 65'd1;
    return t[63:0];
  endfunction

  // up/down arrive already gated by enable
  function automatic ch_op_e decode_op(input logic clr, input logic load,
                                       input logic up, input logic down);
    if (clr)          return OP_CLR;
    if (load)         return OP_LOAD;
    if (up && down)   return OP_HOLD;
    if (up)           return OP_UP;
    if (down)         return OP_DOWN;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/trig_counter_ch.sv
// trig_counter_ch: one counter channel (count register, sticky tc flag).
//   sys_clk, reset       : clock, async active-high reset
//   clr/load/up/down     : one-cycle trigger pulses
//   enable               : gates up/down
//   sat_mode             : MODE_WRAP or MODE_SAT
//   flag_clr             : clears tc_flag (a same-cycle set wins)
//   load_value, step     : shared operands
//   count, tc_flag       : registered outputs
module trig_counter_ch
  import trig_counter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              up,
  input  logic              down,
  input  logic              enable,
  input  logic              sat_mode,
  input  logic              flag_clr,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              tc_flag
);

  localparam logic [63:0]      MAX64 = max_val(WIDTH);
  localparam logic [WIDTH-1:0] MAX   = MAX64[WIDTH-1:0];

  ch_op_e           op;
  logic [WIDTH:0]   step_x, sum, diff;
  logic [WIDTH-1:0] cnt_nxt;
  logic             set_flag, flag_nxt;

  // One extra bit holds the carry/borrow that drives both wrap and clamp.
  always_comb begin
    op                  = decode_op(clr, load, up & enable, down & enable);
    step_x              = '0;
    step_x[STEP_W-1:0]  = step;
    sum                 = {1'b0, count} + step_x;
    diff                = {1'b0, count} - step_x;
    cnt_nxt             = count;
    set_flag            = 1'b0;
    unique case (op)
      OP_CLR:  cnt_nxt = '0;
      OP_LOAD: cnt_nxt = load_value;
      OP_UP: begin
        set_flag = sum[WIDTH];
        cnt_nxt  = (sum[WIDTH] && sat_mode == MODE_SAT) ? MAX : sum[WIDTH-1:0];
      end
      OP_DOWN: begin
        set_flag = diff[WIDTH];
        cnt_nxt  = (diff[WIDTH] && sat_mode == MODE_SAT) ? '0 : diff[WIDTH-1:0];
      end
      default: ;
    endcase

    if (clr)           flag_nxt = 1'b0;
    else if (set_flag) flag_nxt = 1'b1;
    else if (flag_clr) flag_nxt = 1'b0;
    else               flag_nxt = tc_flag;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      tc_flag <= 1'b0;
    end else begin
      count   <= cnt_nxt;
      tc_flag <= flag_nxt;
    end
  end

endmodule

// File: rtl/trig_counter_bank.sv
// trig_counter_bank: NUM_CH trigger-driven up/down counters with sticky
// terminal-count flags and an atomic snapshot of all counters.
//   sys_clk, reset          : clock, async active-high reset
//   trig_clr/load/up/down   : per-channel one-cycle pulses
//   enable, sat_mode        : per-channel levels
//   load_value, step        : shared operands
//   snapshot                : capture all pre-edge counts at once
//   flag_clr                : per-channel tc_flag clear
//   count, snap_count       : channel i at [i*WIDTH +: WIDTH]
//   snap_valid              : one-cycle pulse when snap_count updates
//   tc_flag                 : sticky wrap/clamp flags
module trig_counter_bank
  import trig_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       trig_clr,
  input  logic [NUM_CH-1:0]       trig_load,
  input  logic [NUM_CH-1:0]       trig_up,
  input  logic [NUM_CH-1:0]       trig_down,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       sat_mode,
  input  logic [WIDTH-1:0]        load_value,
  input  logic [STEP_W-1:0]       step,
  input  logic                    snapshot,
  input  logic [NUM_CH-1:0]       flag_clr,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH*WIDTH-1:0] snap_count,
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       tc_flag
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    trig_counter_ch #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_ch (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .clr        (trig_clr[g]),
      .load       (trig_load[g]),
      .up         (trig_up[g]),
      .down       (trig_down[g]),
      .enable     (enable[g]),
      .sat_mode   (sat_mode[g]),
      .flag_clr   (flag_clr[g]),
      .load_value (load_value),
      .step       (step),
      .count      (count[g*WIDTH +: WIDTH]),
      .tc_flag    (tc_flag[g])
    );
  end

  // Registered count is the pre-update value at this edge, so all channels
  // are captured from the same cycle without tearing.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      snap_count <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snapshot;
      if (snapshot) snap_count <= count;
    end
  end

endmodule

// File: tb/tb_trig_counter_bank.sv
module tb_trig_counter_bank;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int STEP_W = 8;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
  localparam longint unsigned MODV = 64'h1_0000_0000;

  logic                    sys_clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       trig_clr, trig_load, trig_up, trig_down;
  logic [NUM_CH-1:0]       enable, sat_mode, flag_clr;
  logic [WIDTH-1:0]        load_value;
  logic [STEP_W-1:0]       step;
  logic                    snapshot;
  logic [NUM_CH*WIDTH-1:0] count, snap_count;
  logic                    snap_valid;
  logic [NUM_CH-1:0]       tc_flag;

  trig_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .trig_clr(trig_clr), .trig_load(trig_load),
    .trig_up(trig_up), .trig_down(trig_down), .enable(enable), .sat_mode(sat_mode),
    .load_value(load_value), .step(step), .snapshot(snapshot), .flag_clr(flag_clr),
    .count(count), .snap_count(snap_count), .snap_valid(snap_valid), .tc_flag(tc_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  longint unsigned m_cnt[NUM_CH];
  longint unsigned m_snap[NUM_CH];
  bit              m_flag[NUM_CH];
  bit              m_sv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int i);
    return 64'(count[i*WIDTH +: WIDTH]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_snap[i] = 0; m_flag[i] = 0;
    end
    m_sv = 0;
  endtask

  // Reference: each channel evaluated with plain wide-integer arithmetic.
  task automatic model_step();
    longint unsigned v;
    bit set;
    if (snapshot) for (int i = 0; i < NUM_CH; i++) m_snap[i] = m_cnt[i];
    m_sv = snapshot;
    for (int i = 0; i < NUM_CH; i++) begin
      set = 0;
      if (trig_clr[i]) begin
        m_cnt[i] = 0; m_flag[i] = 0;
      end else begin
        if (trig_load[i]) m_cnt[i] = load_value;
        else if (enable[i] && trig_up[i] && trig_down[i]) ;
        else if (enable[i] && trig_up[i]) begin
          v = m_cnt[i] + step;
          if (v > MAXV) begin set = 1; v = sat_mode[i] ? MAXV : v - MODV; end
          m_cnt[i] = v;
        end else if (enable[i] && trig_down[i]) begin
          if (longint'(step) > m_cnt[i]) begin
            set = 1; v = sat_mode[i] ? 0 : m_cnt[i] + MODV - step;
          end else v = m_cnt[i] - step;
          m_cnt[i] = v;
        end
        if (set) m_flag[i] = 1;
        else if (flag_clr[i]) m_flag[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("count%0d", i), cnt_of(i), m_cnt[i]);
      chk($sformatf("snap%0d", i), 64'(snap_count[i*WIDTH +: WIDTH]), m_snap[i]);
      chk($sformatf("flag%0d", i), 64'(tc_flag[i]), 64'(m_flag[i]));
    end
    chk("snap_valid", 64'(snap_valid), 64'(m_sv));
  endtask

  task automatic clr_pulses();
    trig_clr = '0; trig_load = '0; trig_up = '0; trig_down = '0;
    flag_clr = '0; snapshot = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk); #1;
    compare_all();
    clr_pulses();
  endtask

  initial begin
    clr_pulses();
    reset = 1'b1; enable = '1; sat_mode = '0; load_value = '0; step = 8'd1;
    model_reset();
    #12;
    compare_all();
    chk("reset_count", 64'(count), 64'd0);
    @(negedge sys_clk); reset = 1'b0;
    @(posedge sys_clk); #1;

    // 1: five ups on ch0
    for (int k = 0; k < 5; k++) begin trig_up = 4'b0001; tick(); end
    chk("t1_cnt0", cnt_of(0), 64'd5);
    chk("t1_cnt1", cnt_of(1), 64'd0);
    chk("t1_flag", 64'(tc_flag), 64'd0);

    // 2: wrap across max
    load_value = 32'hFFFF_FFFE; trig_load = 4'b0001; tick();
    step = 8'd3; trig_up = 4'b0001; tick();
    chk("t2_wrap", cnt_of(0), 64'd1);
    chk("t2_flag", 64'(tc_flag[0]), 64'd1);
    flag_clr = 4'b0001; tick();
    chk("t2_fclr", 64'(tc_flag[0]), 64'd0);

    // 3: saturate at zero
    sat_mode = 4'b0001; load_value = 32'd2; trig_load = 4'b0001; tick();
    step = 8'd5; trig_down = 4'b0001; tick();
    chk("t3_sat0", cnt_of(0), 64'd0);
    chk("t3_flag", 64'(tc_flag[0]), 64'd1);
    trig_down = 4'b0001; tick();
    chk("t3_hold", cnt_of(0), 64'd0);
    chk("t3_flag2", 64'(tc_flag[0]), 64'd1);

    // 4: priority on ch1
    step = 8'd1; load_value = 32'h10;
    trig_clr = 4'b0010; trig_load = 4'b0010; trig_up = 4'b0010; tick();
    chk("t4_clr", cnt_of(1), 64'd0);
    trig_load = 4'b0010; tick();
    trig_up = 4'b0010; trig_down = 4'b0010; tick();
    chk("t4_updn", cnt_of(1), 64'h10);
    enable = 4'b1101; trig_up = 4'b0010; tick();
    chk("t4_dis", cnt_of(1), 64'h10);
    load_value = 32'h1234; trig_load = 4'b0010; tick();
    chk("t4_load", cnt_of(1), 64'h1234);
    enable = '1;

    // 5: snapshot on ch2 while counting
    load_value = 32'd100; trig_load = 4'b0100; tick();
    for (int k = 0; k < 7; k++) begin trig_up = 4'b0100; tick(); end
    trig_up = 4'b0100; snapshot = 1'b1; tick();
    chk("t5_snap", 64'(snap_count[2*WIDTH +: WIDTH]), 64'd107);
    chk("t5_sv", 64'(snap_valid), 64'd1);
    chk("t5_live", cnt_of(2), 64'd108);
    trig_up = 4'b0100; tick();
    chk("t5_sv0", 64'(snap_valid), 64'd0);
    chk("t5_held", 64'(snap_count[2*WIDTH +: WIDTH]), 64'd107);
    chk("t5_live2", cnt_of(2), 64'd109);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      trig_clr  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      trig_load = 4'($urandom) & 4'($urandom);
      trig_up   = 4'($urandom);
      trig_down = 4'($urandom);
      flag_clr  = 4'($urandom) & 4'($urandom);
      snapshot  = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) enable   = 4'($urandom) | 4'($urandom);
      if ($urandom_range(31) == 0) sat_mode = 4'($urandom);
      case ($urandom_range(3))
        0: load_value = 32'hFFFF_FFFF - 32'($urandom_range(3));
        1: load_value = 32'($urandom_range(3));
        default: load_value = $urandom;
      endcase
      step = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      tick();
    end

    // 6: async reset mid-count with triggers active
    enable = '1; sat_mode = '0; step = 8'd4;
    trig_up = '1; tick();
    trig_up = '1; trig_load = 4'b1000; snapshot = 1'b1;
    @(posedge sys_clk); #3;
    reset = 1'b1; #1;
    model_reset();
    compare_all();
    chk("t6_async", 64'(count), 64'd0);
    @(posedge sys_clk); #1;
    compare_all();
    @(negedge sys_clk); reset = 1'b0; clr_pulses();
    #2;
    trig_up = 4'b0001; tick();
    chk("t6_first", cnt_of(0), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
